// File: rtl/cssub_seq.sv
// Carry-select subtractor, one 4-bit slice per clock; result NIBBLES cycles after accept, held while out_ready_i is low.
// Define CSSUB_SAT_EN to saturate d to 0 whenever the final borrow is set.
module cssub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [4*NIBBLES-1:0] a_i,
  input  logic [4*NIBBLES-1:0] b_i,
  input  logic                 bin_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [4*NIBBLES-1:0] d_o,
  output logic                 bout_o
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    d_q, d_d;
  logic            brw_q, brw_d;
  logic            bout_q, bout_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [3:0]      x, y;
  logic [4:0]      cand0, cand1, sel;
  logic            brw_nxt;

  // Both borrow-in candidates are formed up front; the running borrow only picks one.
  assign x       = a_q[{idx_q, 2'b00} +: 4];
  assign y       = b_q[{idx_q, 2'b00} +: 4];
  assign cand0   = {1'b0, x} + {1'b0, ~y} + 5'd1;
  assign cand1   = {1'b0, x} + {1'b0, ~y};
  assign sel     = brw_q ? cand1 : cand0;
  assign brw_nxt = ~sel[4];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = RUN;
          a_d     = a_i;
          b_d     = b_i;
          brw_d   = bin_i;
          idx_d   = '0;
          d_d     = '0;
        end
      end
      RUN: begin
        d_d[{idx_q, 2'b00} +: 4] = sel[3:0];
        brw_d = brw_nxt;
        if (idx_q == LAST) begin
          state_d = DONE;
          bout_d  = brw_nxt;
`ifdef CSSUB_SAT_EN
          if (brw_nxt) begin
            d_d = '0;
          end
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign d_o         = d_q;
  assign bout_o      = bout_q;

endmodule

// File: tb/tb_cssub_seq.sv
// Randomized bench for cssub_seq (NIBBLES=4) against an arithmetic reference and cycle-count handshake model.
module tb_cssub_seq;
  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        bin_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] d_o;
  logic        bout_o;

  int tests = 0;
  int fails = 0;

  // Handshake model: ops in flight, accept cycle, and expected {bout,d}.
  int          cyc = 0;
  int          acc = 0;
  bit          inflight = 0;
  logic [16:0] expq[$];
  logic [15:0] got_d = '0;
  logic        got_b = 1'b0;

  cssub_seq #(.NIBBLES(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .bin_i      (bin_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .d_o        (d_o),
    .bout_o     (bout_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int unsigned ai, bi;
    logic [15:0] d;
    logic        bo;
    ai = a;
    bi = b + bin;
    bo = (ai < bi);
    d  = 16'((ai + 32'h10000 - bi) % 32'h10000);
`ifdef CSSUB_SAT_EN
    if (bo) d = 16'h0000;
`endif
    return {bo, d};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight = 0;
      expq.delete();
    end else begin
      if (!inflight) begin
        if (in_valid_i) begin
          inflight = 1;
          acc = cyc + 1;
          expq.push_back(ref_sub(a_i, b_i, bin_i));
        end
      end else if ((cyc - acc >= N) && out_ready_i) begin
        inflight = 0;
        void'(expq.pop_front());
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    bit exp_ov;
    if (!rst_n) begin
      chk("rst_in_ready", in_ready_o, 1);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_d", d_o, 0);
      chk("rst_bout", bout_o, 0);
    end else begin
      exp_ov = inflight && (cyc - acc >= N);
      chk("in_ready", in_ready_o, !inflight);
      chk("out_valid", out_valid_o, exp_ov);
      if (exp_ov && out_valid_o && expq.size() > 0) begin
        chk("d", d_o, expq[0][15:0]);
        chk("bout", bout_o, expq[0][16]);
        got_d = d_o;
        got_b = bout_o;
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin, input int stall);
    int n;
    n = 0;
    while (!in_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", n >= 100, 0);
    in_valid_i  = 1'b1;
    a_i         = a;
    b_i         = b;
    bin_i       = bin;
    out_ready_i = (stall == 0);
    @(posedge clk);
    #1;
    n = 0;
    // Scramble operands and pulse in_valid while busy; none of it may matter.
    while (n < 100) begin
      a_i        = 16'($urandom);
      b_i        = 16'($urandom);
      bin_i      = 1'($urandom);
      in_valid_i = 1'($urandom);
      @(negedge clk);
      if (out_valid_o) break;
      n++;
    end
    in_valid_i = 1'b0;
    chk("done_timeout", n >= 100, 0);
    repeat (stall) @(negedge clk);
    out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    in_valid_i  = 1'b0;
    a_i         = '0;
    b_i         = '0;
    bin_i       = 1'b0;
    out_ready_i = 1'b1;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0, 0);
    chk("t1_d", got_d, 16'h1000);
    chk("t1_bout", got_b, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    chk("t2_d", got_d, 16'h7FFF);
    chk("t2_bout", got_b, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
`ifdef CSSUB_SAT_EN
    chk("t3_d", got_d, 16'h0000);
`else
    chk("t3_d", got_d, 16'hFFFF);
`endif
    chk("t3_bout", got_b, 1);
    run_op(16'hABCD, 16'hABCD, 1'b1, 0);
`ifdef CSSUB_SAT_EN
    chk("t4_d", got_d, 16'h0000);
`else
    chk("t4_d", got_d, 16'hFFFF);
`endif
    chk("t4_bout", got_b, 1);
    run_op(16'hABCD, 16'hABCD, 1'b0, 5);
    chk("t5_d", got_d, 16'h0000);
    chk("t5_bout", got_b, 0);

    // Abort two cycles into RUN, then a clean operation right after release.
    in_valid_i = 1'b1;
    a_i = 16'h5555;
    b_i = 16'h1111;
    bin_i = 1'b0;
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(16'h9876, 16'h1234, 1'b1, 0);
    chk("t6_d", got_d, 16'h8641);
    chk("t6_bout", got_b, 0);

    for (int i = 0; i < 150; i++) begin
      int st;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      run_op(16'($urandom), 16'($urandom), 1'($urandom), st);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
